// File: rtl/gates_reduce_stream.sv
// Streaming AND/OR/XOR reduction over packets of WIDTH-bit beats.
// One registered result per packet, with a saturating beat count, on a valid/ready output.
module gates_reduce_stream #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_and,
  output logic             out_or,
  output logic             out_xor,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state;
  logic             acc_and;
  logic             acc_or;
  logic             acc_xor;
  logic [CNT_W-1:0] cnt;
  logic             acc_ovf;

  logic             accept;
  logic             next_and;
  logic             next_or;
  logic             next_xor;
  logic [CNT_W-1:0] next_cnt;
  logic             next_ovf;

  assign in_ready = !rst && (state != HOLD);
  assign accept   = in_valid && in_ready;

  // Accumulator values with the current beat folded in; used both for the
  // running state and for the result on the last beat.
  always_comb begin
    next_and = acc_and & (&in_data);
    next_or  = acc_or  | (|in_data);
    next_xor = acc_xor ^ (^in_data);
    next_cnt = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
    next_ovf = acc_ovf | (cnt == CNT_MAX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      acc_and   <= 1'b1;
      acc_or    <= 1'b0;
      acc_xor   <= 1'b0;
      cnt       <= '0;
      acc_ovf   <= 1'b0;
      out_valid <= 1'b0;
      out_and   <= 1'b0;
      out_or    <= 1'b0;
      out_xor   <= 1'b0;
      out_count <= '0;
      out_ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE, ACCUM: begin
          if (accept) begin
            if (in_last) begin
              // Publish the folded result and start the next packet clean.
              out_and   <= next_and;
              out_or    <= next_or;
              out_xor   <= next_xor;
              out_count <= next_cnt;
              out_ovf   <= next_ovf;
              out_valid <= 1'b1;
              acc_and   <= 1'b1;
              acc_or    <= 1'b0;
              acc_xor   <= 1'b0;
              cnt       <= '0;
              acc_ovf   <= 1'b0;
              state     <= HOLD;
            end else begin
              acc_and <= next_and;
              acc_or  <= next_or;
              acc_xor <= next_xor;
              cnt     <= next_cnt;
              acc_ovf <= next_ovf;
              state   <= ACCUM;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gates_reduce_stream.sv
// Directed bench for gates_reduce_stream: model predicts each packet result
// into a scoreboard queue, popped and compared when the DUT presents it.
module tb_gates_reduce_stream;

  localparam int WIDTH = 4;
  localparam int CNT_W = 4;

  typedef struct {
    logic             r_and;
    logic             r_or;
    logic             r_xor;
    logic [CNT_W-1:0] r_count;
    logic             r_ovf;
  } res_t;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic             out_and;
  logic             out_or;
  logic             out_xor;
  logic [CNT_W-1:0] out_count;
  logic             out_ovf;

  int compared   = 0;
  int mismatched = 0;

  res_t sb[$];
  res_t last_exp;

  logic             m_and;
  logic             m_or;
  logic             m_xor;
  logic [CNT_W-1:0] m_cnt;
  logic             m_ovf;

  gates_reduce_stream #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_and   (out_and),
    .out_or    (out_or),
    .out_xor   (out_xor),
    .out_count (out_count),
    .out_ovf   (out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check1(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_and = 1'b1;
    m_or  = 1'b0;
    m_xor = 1'b0;
    m_cnt = '0;
    m_ovf = 1'b0;
  endtask

  task automatic model_beat(input logic [WIDTH-1:0] data, input logic last);
    res_t r;
    m_and = m_and & (data == {WIDTH{1'b1}});
    m_or  = m_or  | (data != '0);
    m_xor = m_xor ^ (($countones(data) % 2) == 1);
    if (m_cnt == 4'd15) m_ovf = 1'b1;
    else                m_cnt = m_cnt + 4'd1;
    if (last) begin
      r.r_and   = m_and;
      r.r_or    = m_or;
      r.r_xor   = m_xor;
      r.r_count = m_cnt;
      r.r_ovf   = m_ovf;
      sb.push_back(r);
      model_reset();
    end
  endtask

  task automatic applyStimulus(input logic [WIDTH-1:0] data, input logic last);
    check1("in_ready_before_beat", 32'(in_ready), 32'd1);
    model_beat(data, last);
    in_valid = 1'b1;
    in_data  = data;
    in_last  = last;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_fields(input string tag, input res_t e);
    check1({tag, "_and"},   32'(out_and),   32'(e.r_and));
    check1({tag, "_or"},    32'(out_or),    32'(e.r_or));
    check1({tag, "_xor"},   32'(out_xor),   32'(e.r_xor));
    check1({tag, "_count"}, 32'(out_count), 32'(e.r_count));
    check1({tag, "_ovf"},   32'(out_ovf),   32'(e.r_ovf));
  endtask

  // Called one step after the last beat's edge: the result must already be valid.
  task automatic checkOutput(input string tag);
    res_t e;
    check1({tag, "_valid"}, 32'(out_valid), 32'd1);
    check1({tag, "_in_ready_hold"}, 32'(in_ready), 32'd0);
    if (sb.size() == 0) begin
      mismatched++;
      $error("[TB] FAIL %s_scoreboard: observed empty queue expected entry", tag);
    end else begin
      e = sb.pop_front();
      last_exp = e;
      check_fields(tag, e);
    end
  endtask

  task automatic acceptOutput(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check1({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
    check1({tag, "_in_ready_back"}, 32'(in_ready), 32'd1);
    check_fields({tag, "_retain"}, last_exp);
  endtask

  initial begin
    res_t zero;
    zero.r_and = 1'b0; zero.r_or = 1'b0; zero.r_xor = 1'b0;
    zero.r_count = '0; zero.r_ovf = 1'b0;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    model_reset();
    $display("[TB] start");

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check1("rst_out_valid", 32'(out_valid), 32'd0);
    check1("rst_in_ready", 32'(in_ready), 32'd0);
    check_fields("rst", zero);
    rst = 1'b0;
    #1;
    check1("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Single-beat packet
    applyStimulus(4'b1111, 1'b1);
    checkOutput("single");
    acceptOutput("single");

    // Multi-beat with gaps in in_valid
    applyStimulus(4'b1111, 1'b0);
    check1("multi_no_early_valid", 32'(out_valid), 32'd0);
    idle(2);
    check1("multi_gap_valid", 32'(out_valid), 32'd0);
    applyStimulus(4'b1111, 1'b0);
    applyStimulus(4'b0111, 1'b1);
    checkOutput("multi");
    acceptOutput("multi");

    // Backpressure: result held, upstream beat blocked
    applyStimulus(4'b1010, 1'b1);
    checkOutput("bp_first");
    in_valid = 1'b1;
    in_data  = 4'b0000;
    in_last  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check1("bp_in_ready", 32'(in_ready), 32'd0);
      check1("bp_valid_held", 32'(out_valid), 32'd1);
      check_fields("bp_stable", last_exp);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check1("bp_release_valid", 32'(out_valid), 32'd0);
    check1("bp_release_in_ready", 32'(in_ready), 32'd1);
    check_fields("bp_release_retain", last_exp);
    model_beat(4'b0000, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    checkOutput("bp_second");
    acceptOutput("bp_second");

    // Saturating count
    for (int i = 0; i < 17; i++) applyStimulus(4'b0001, (i == 16));
    checkOutput("sat");
    acceptOutput("sat");

    // Reset mid-packet discards the partial packet
    applyStimulus(4'b1000, 1'b0);
    applyStimulus(4'b1000, 1'b0);
    rst = 1'b1;
    #1;
    check1("midrst_in_ready", 32'(in_ready), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    check1("midrst_valid", 32'(out_valid), 32'd0);
    idle(2);
    check1("midrst_no_pulse", 32'(out_valid), 32'd0);
    applyStimulus(4'b0000, 1'b1);
    checkOutput("midrst_after");
    acceptOutput("midrst_after");

    // Reset while holding a result
    applyStimulus(4'b1111, 1'b1);
    checkOutput("holdrst_pre");
    rst = 1'b1;
    @(posedge clk);
    #1;
    check1("holdrst_valid", 32'(out_valid), 32'd0);
    check_fields("holdrst", zero);
    rst = 1'b0;
    #1;
    check1("holdrst_in_ready", 32'(in_ready), 32'd1);
    idle(1);
    check1("holdrst_no_pulse", 32'(out_valid), 32'd0);

    check1("sb_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
